// File: rtl/keccak_pkg.sv
// keccak_pkg
// Shared constants and types for the Keccak/SHAKE output path.
//   WORD_WIDTH     : width of one output word (one Keccak lane)
//   RATE_SHAKE128  : rate of SHAKE128 in bits, also the width of the rate bus
//   RATE_SHAKE256  : rate of SHAKE256 in bits
//   MODE_*         : operation mode encodings
//   dump_state_e   : state of the output dump sequencer
package keccak_pkg;

    localparam int WORD_WIDTH    = 64;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam int WORD_IDX_W    = 5;
    localparam int BLOCK_BITS_W  = 11;

    localparam logic [1:0] MODE_SHAKE128 = 2'b00;
    localparam logic [1:0] MODE_SHAKE256 = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dump_state_e;

    // Rate in bits for a mode; any encoding other than SHAKE256 uses the
    // SHAKE128 rate.
    function automatic logic [BLOCK_BITS_W-1:0] mode_rate(input logic [1:0] mode);
        if (mode == MODE_SHAKE256) begin
            return BLOCK_BITS_W'(RATE_SHAKE256);
        end
        return BLOCK_BITS_W'(RATE_SHAKE128);
    endfunction

endpackage

// File: rtl/dump_fsm.sv
// dump_fsm
// IDLE/SEND sequencer and word index for the output dump stage.
//   clk, rst       : clock, synchronous active-high reset
//   start          : accepted buffer write (only meaningful in IDLE)
//   dout_ready     : consumer accepts the current word
//   last_word_idx  : index of the final word of the captured block
//   sending        : high while in SEND (a word is presented)
//   word_idx       : index of the word currently presented
module dump_fsm
    import keccak_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dout_ready,
    input  logic [WORD_IDX_W-1:0] last_word_idx,
    output logic                  sending,
    output logic [WORD_IDX_W-1:0] word_idx
);

    dump_state_e           state_q;
    logic [WORD_IDX_W-1:0] word_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_SEND;
                        word_idx_q <= '0;
                    end
                end
                ST_SEND: begin
                    if (dout_ready) begin
                        if (word_idx_q == last_word_idx) begin
                            state_q    <= ST_IDLE;
                            word_idx_q <= '0;
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    word_idx_q <= '0;
                end
            endcase
        end
    end

    assign sending  = (state_q == ST_SEND);
    assign word_idx = word_idx_q;

endmodule

// File: rtl/dump_stage.sv
// dump_stage
// Captures one rate block from the permute stage and streams it out as
// 64-bit words with a valid/ready handshake.
//   clk, rst                : clock, synchronous active-high reset
//   rate_input              : rate portion of the state, lane 0 in [63:0]
//   output_size_counter     : output bits still owed, this block included
//   operation_mode_in       : SHAKE128 / SHAKE256 mode of the block
//   output_buffer_we        : write strobe for the three inputs above
//   output_buffer_available : buffer empty, a write will be accepted
//   dout / dout_valid / dout_ready : output word handshake
//   dout_valid_bits         : valid bit count of dout (1..64, 0 when idle)
//   dout_last               : final word of this block
//   dout_final              : final word of the whole output
module dump_stage
    import keccak_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RATE_SHAKE128-1:0] rate_input,
    input  logic [31:0]              output_size_counter,
    input  logic [1:0]               operation_mode_in,
    input  logic                     output_buffer_we,
    output logic                     output_buffer_available,
    output logic [WORD_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [6:0]               dout_valid_bits,
    output logic                     dout_last,
    output logic                     dout_final
);

    // Bits of the block to emit: the rate, or fewer if the output ends here.
    function automatic logic [BLOCK_BITS_W-1:0] sat_block_bits(
        input logic [31:0]             remaining,
        input logic [BLOCK_BITS_W-1:0] rate
    );
        if (remaining < {{(32-BLOCK_BITS_W){1'b0}}, rate}) begin
            return remaining[BLOCK_BITS_W-1:0];
        end
        return rate;
    endfunction

    // Keep the low 'bits' bits of a word (bits is 1..64).
    function automatic logic [WORD_WIDTH-1:0] word_mask(input logic [6:0] bits);
        if (bits >= 7'd64) begin
            return '1;
        end
        return (64'd1 << bits) - 64'd1;
    endfunction

    logic [RATE_SHAKE128-1:0] rate_q, rate_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [1:0]               mode_q, mode_d;

    logic                     sending;
    logic                     accept;
    logic [WORD_IDX_W-1:0]    word_idx;
    logic [WORD_IDX_W-1:0]    last_word_idx;
    logic [BLOCK_BITS_W-1:0]  rate_bits;
    logic [BLOCK_BITS_W-1:0]  block_bits;
    logic [BLOCK_BITS_W-1:0]  word_base;
    logic [6:0]               tail_bits;
    logic [WORD_WIDTH-1:0]    word_raw;
    logic                     is_last;

    // Writes are taken only while idle and only when output is still owed.
    assign accept = !sending && output_buffer_we && (output_size_counter != 32'd0);

    always_comb begin
        rate_d = rate_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (accept) begin
            rate_d = rate_input;
            cnt_d  = output_size_counter;
            mode_d = operation_mode_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_SHAKE128;
        end else begin
            rate_q <= rate_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    // Block geometry derived from the captured counter and mode.
    assign rate_bits     = mode_rate(mode_q);
    assign block_bits    = sat_block_bits(cnt_q, rate_bits);
    assign last_word_idx = WORD_IDX_W'((block_bits - 1'b1) >> 6);
    assign tail_bits     = 7'(block_bits - {last_word_idx, 6'd0});

    dump_fsm u_fsm (
        .clk           (clk),
        .rst           (rst),
        .start         (accept),
        .dout_ready    (dout_ready),
        .last_word_idx (last_word_idx),
        .sending       (sending),
        .word_idx      (word_idx)
    );

    // Outputs depend only on held state, so they stay stable under backpressure.
    assign word_base = {word_idx, 6'd0};
    assign word_raw  = rate_q[word_base +: WORD_WIDTH];
    assign is_last   = sending && (word_idx == last_word_idx);

    assign output_buffer_available = !sending;
    assign dout_valid      = sending;
    assign dout_valid_bits = !sending ? 7'd0 : (is_last ? tail_bits : 7'd64);
    assign dout            = sending ? (word_raw & word_mask(dout_valid_bits)) : '0;
    assign dout_last       = is_last;
    assign dout_final      = is_last && (cnt_q <= {{(32-BLOCK_BITS_W){1'b0}}, rate_bits});

endmodule

// File: tb/tb_dump_stage.sv
// tb_dump_stage
// Self-checking bench for dump_stage: a queue-based model of the expected
// word stream is checked against the DUT on every negative clock edge, and
// directed scenarios add literal expectations on specific words.
module tb_dump_stage;
    import keccak_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [RATE_SHAKE128-1:0] rate_input = '0;
    logic [31:0]              output_size_counter = '0;
    logic [1:0]               operation_mode_in = '0;
    logic                     output_buffer_we = 1'b0;
    logic                     output_buffer_available;
    logic [63:0]              dout;
    logic                     dout_valid;
    logic                     dout_ready = 1'b1;
    logic [6:0]               dout_valid_bits;
    logic                     dout_last;
    logic                     dout_final;

    dump_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .rate_input              (rate_input),
        .output_size_counter     (output_size_counter),
        .operation_mode_in       (operation_mode_in),
        .output_buffer_we        (output_buffer_we),
        .output_buffer_available (output_buffer_available),
        .dout                    (dout),
        .dout_valid              (dout_valid),
        .dout_ready              (dout_ready),
        .dout_valid_bits         (dout_valid_bits),
        .dout_last               (dout_last),
        .dout_final              (dout_final)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] data;
        int          bits;
        bit          last;
        bit          fin;
    } word_t;

    word_t exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            if (dout_ready) void'(exp_q.pop_front());
        end else if (output_buffer_we && output_size_counter > 0) begin
            int rate, bb, nw;
            rate = (operation_mode_in == 2'b01) ? 1088 : 1344;
            bb   = (output_size_counter < rate) ? int'(output_size_counter) : rate;
            nw   = (bb + 63) / 64;
            for (int k = 0; k < nw; k++) begin
                word_t w;
                w.data = rate_input[64*k +: 64];
                w.bits = (k == nw - 1) ? bb - 64 * (nw - 1) : 64;
                for (int b = 0; b < 64; b++) if (b >= w.bits) w.data[b] = 1'b0;
                w.last = (k == nw - 1);
                w.fin  = w.last && (output_size_counter <= rate);
                exp_q.push_back(w);
            end
        end
    end

    // ---------------- cycle-by-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid", {63'd0, dout_valid}, {63'd0, exp_q.size() > 0});
            chk("available", {63'd0, output_buffer_available}, {63'd0, exp_q.size() == 0});
            if (exp_q.size() > 0) begin
                chk("dout", dout, exp_q[0].data);
                chk("valid_bits", {57'd0, dout_valid_bits}, 64'(exp_q[0].bits));
                chk("last", {63'd0, dout_last}, {63'd0, exp_q[0].last});
                chk("final", {63'd0, dout_final}, {63'd0, exp_q[0].fin});
            end else begin
                chk("idle_dout", dout, 64'd0);
                chk("idle_bits", {57'd0, dout_valid_bits}, 64'd0);
            end
        end
    end

    // Handshake log of what the DUT actually delivered.
    int          hs_count = 0;
    logic [63:0] hs_data;
    logic [6:0]  hs_bits;
    logic        hs_last, hs_final;

    always @(posedge clk) begin
        if (dout_valid && dout_ready) begin
            hs_count <= hs_count + 1;
            hs_data  <= dout;
            hs_bits  <= dout_valid_bits;
            hs_last  <= dout_last;
            hs_final <= dout_final;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Lane k = {C0DE0000+k, 00001000+k}
    task automatic load_pattern();
        for (int k = 0; k < 21; k++) begin
            rate_input[64*k +: 64] = {32'hC0DE0000 + 32'(k), 32'h00001000 + 32'(k)};
        end
    endtask

    task automatic write_block(input logic [1:0] mode, input logic [31:0] cnt);
        @(posedge clk); #1;
        operation_mode_in   = mode;
        output_size_counter = cnt;
        output_buffer_we    = 1'b1;
        @(posedge clk); #1;
        output_buffer_we    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        @(negedge clk);
        while (!output_buffer_available && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_timeout"}, {63'd0, output_buffer_available}, 64'd1);
    endtask

    task automatic wait_hs(input int target, input string name);
        int cyc = 0;
        while (hs_count < target && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_hs_timeout"}, 64'(hs_count), 64'(target));
    endtask

    int base;
    logic [63:0] snap_dout;
    logic [6:0]  snap_bits;

    initial begin
        load_pattern();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("rst_avail", {63'd0, output_buffer_available}, 64'd1);
        chk("rst_dout", dout, 64'd0);
        chk("rst_bits", {57'd0, dout_valid_bits}, 64'd0);
        chk("rst_lastfinal", {62'd0, dout_last, dout_final}, 64'd0);

        // A write with zero bits owed is ignored
        write_block(MODE_SHAKE128, 32'd0);
        @(negedge clk);
        chk("zero_cnt_avail", {63'd0, output_buffer_available}, 64'd1);

        // SHAKE128, 256 bits: 4 words
        base = hs_count;
        write_block(MODE_SHAKE128, 32'd256);
        wait_idle("s128_256");
        chk("s128_256_words", 64'(hs_count - base), 64'd4);
        chk("s128_256_w3", hs_data, 64'hC0DE0003_00001003);
        chk("s128_256_flags", {56'd0, hs_bits, hs_final}, {56'd0, 7'd64, 1'b1});

        // SHAKE128, 5000 bits: full 21-word block, not final
        base = hs_count;
        write_block(MODE_SHAKE128, 32'd5000);
        wait_idle("s128_5000");
        chk("s128_5000_words", 64'(hs_count - base), 64'd21);
        chk("s128_5000_lf", {62'd0, hs_last, hs_final}, 64'b10);
        chk("s128_5000_w20", hs_data, 64'hC0DE0014_00001014);

        // SHAKE256, 100 bits: 2 words, 36 valid bits in the tail
        base = hs_count;
        write_block(MODE_SHAKE256, 32'd100);
        wait_idle("s256_100");
        chk("s256_100_words", 64'(hs_count - base), 64'd2);
        chk("s256_100_w1", hs_data, 64'h00000001_00001001);
        chk("s256_100_bits", {57'd0, hs_bits}, 64'd36);
        chk("s256_100_lf", {62'd0, hs_last, hs_final}, 64'b11);

        // SHAKE256, 1088 bits: 17 words, with a stray write during SEND
        base = hs_count;
        write_block(MODE_SHAKE256, 32'd1088);
        repeat (3) @(posedge clk);
        write_block(MODE_SHAKE128, 32'd64);
        wait_idle("s256_1088");
        chk("s256_1088_words", 64'(hs_count - base), 64'd17);
        chk("s256_1088_lf", {62'd0, hs_last, hs_final}, 64'b11);
        chk("s256_1088_bits", {57'd0, hs_bits}, 64'd64);

        // Unused mode encoding uses the SHAKE128 rate
        base = hs_count;
        write_block(2'b11, 32'd2000);
        wait_idle("mode3");
        chk("mode3_words", 64'(hs_count - base), 64'd21);
        chk("mode3_lf", {62'd0, hs_last, hs_final}, 64'b10);

        // Backpressure at word 2 for 5 cycles
        base = hs_count;
        write_block(MODE_SHAKE128, 32'd5000);
        wait_hs(base + 2, "bp");
        dout_ready = 1'b0;
        @(negedge clk);
        snap_dout = dout;
        snap_bits = dout_valid_bits;
        chk("bp_word2", snap_dout, 64'hC0DE0002_00001002);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_dout", dout, snap_dout);
            chk("bp_hold_bits", {57'd0, dout_valid_bits}, {57'd0, snap_bits});
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_resume_w3", dout, 64'hC0DE0003_00001003);
        wait_idle("bp");
        chk("bp_words", 64'(hs_count - base), 64'd21);

        // Reset in the middle of a block
        base = hs_count;
        write_block(MODE_SHAKE128, 32'd5000);
        wait_hs(base + 5, "mid_rst");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("mid_rst_avail", {63'd0, output_buffer_available}, 64'd1);
        write_block(MODE_SHAKE256, 32'd128);
        @(negedge clk);
        chk("post_rst_w0", dout, 64'hC0DE0000_00001000);
        wait_idle("post_rst");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
